// File: rtl/gates_sequencer.sv
// Self-test sequencer for the board's gates block: walks a/b through all four vectors
// (auto dwell or debounced button), captures each result onto the LEDs and flags wrong answers.
module gates_sequencer #(
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       sw_auto,
  input  logic [3:0] y_in,
  output logic       a_out,
  output logic       b_out,
  output logic [1:0] vec,
  output logic [3:0] led,
  output logic       result_valid,
  output logic       mismatch,
  output logic [1:0] err_vec
);

  localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DWW-1:0] DWELL_LAST  = DWW'(DWELL_CYCLES - 1);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_MAX     = DBW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {SETTLE, CHECK, WAIT} state_t;

  state_t         state, state_nxt;
  logic [STW-1:0] settle_cnt, settle_nxt;
  logic [DWW-1:0] dwell_cnt, dwell_nxt;
  logic           capture, advance;
  logic           btn_s1, btn_s2, sw_s1, sw_s2;
  logic           deb_level, step;
  logic [DBW-1:0] deb_cnt;
  logic [3:0]     expected;
  logic [1:0]     vec_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= 1'b0;
      sw_s2  <= 1'b0;
    end else begin
      btn_s1 <= btn_step;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_auto;
      sw_s2  <= sw_s1;
    end
  end

  // The level flips only after the synced button disagrees with it for DEBOUNCE_CYCLES+1 samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      step      <= 1'b0;
    end else begin
      step <= 1'b0;
      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        deb_level <= btn_s2;
        deb_cnt   <= '0;
        step      <= btn_s2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      dwell_cnt  <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    dwell_nxt  = dwell_cnt;
    capture    = 1'b0;
    advance    = 1'b0;
    unique case (state)
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt  = CHECK;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      CHECK: begin
        capture   = 1'b1;
        state_nxt = WAIT;
        dwell_nxt = '0;
      end
      WAIT: begin
        // Step pulses are honoured in either mode; dwell only accumulates while auto is on.
        advance = step || (sw_s2 && (dwell_cnt == DWELL_LAST));
        if (advance) begin
          state_nxt  = SETTLE;
          settle_nxt = '0;
          dwell_nxt  = '0;
        end else if (sw_s2) begin
          dwell_nxt = dwell_cnt + 1'b1;
        end else begin
          dwell_nxt = '0;
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_comb begin
    expected = 4'b0111;
    unique case (vec)
      2'd0:    expected = 4'b1000;
      2'd1:    expected = 4'b1110;
      2'd2:    expected = 4'b1110;
      default: expected = 4'b0111;
    endcase
  end

  assign vec_inc = vec + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec          <= 2'd0;
      a_out        <= 1'b0;
      b_out        <= 1'b0;
      led          <= 4'd0;
      result_valid <= 1'b0;
      mismatch     <= 1'b0;
      err_vec      <= 2'd0;
    end else begin
      result_valid <= capture;
      if (capture) begin
        led <= y_in;
        if ((y_in != expected) && !mismatch) begin
          mismatch <= 1'b1;
          err_vec  <= vec;
        end
      end
      if (advance) begin
        vec   <= vec_inc;
        a_out <= vec_inc[1];
        b_out <= vec_inc[0];
      end
    end
  end

endmodule

// File: tb/tb_gates_sequencer.sv
// Bench for gates_sequencer: a timeline model of the sequencer plus a table model of the
// gates block, compared every cycle, with hand-computed checkpoints along a directed run.
module tb_gates_sequencer;

  localparam int DWELL  = 8;
  localparam int DEB    = 4;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n, btn_step, sw_auto, fault_en;
  logic [3:0] y_in;
  logic       a_out, b_out, result_valid, mismatch;
  logic [1:0] vec, err_vec;
  logic [3:0] led;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  gates_sequencer #(
    .DWELL_CYCLES   (DWELL),
    .DEBOUNCE_CYCLES(DEB),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_step    (btn_step),
    .sw_auto     (sw_auto),
    .y_in        (y_in),
    .a_out       (a_out),
    .b_out       (b_out),
    .vec         (vec),
    .led         (led),
    .result_valid(result_valid),
    .mismatch    (mismatch),
    .err_vec     (err_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [3:0] gates_resp(input logic [1:0] v);
    case (v)
      2'd0:    return 4'h8;
      2'd1:    return 4'hE;
      2'd2:    return 4'hE;
      default: return 4'h7;
    endcase
  endfunction

  function automatic logic [3:0] board_y(input logic [1:0] v, input logic f);
    logic [3:0] y;
    y = gates_resp(v);
    if (f && v == 2'd2) y[2] = 1'b0;
    return y;
  endfunction

  assign y_in = board_y({a_out, b_out}, fault_en);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic btn, input logic sw, input int n);
    btn_step = btn;
    sw_auto  = sw;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValid(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (result_valid) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("[TB] FAIL wait_valid: no result_valid within %0d cycles", limit);
  endtask

  // Timeline model: edges since the last vector change decide settle/capture/wait.
  int         m_since, m_auto_run, m_diff_run;
  logic [1:0] m_vec, m_err, m_btn_hist, m_sw_hist;
  logic [3:0] m_led;
  logic       m_rv, m_mis, m_deb, m_step;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    logic       in_check, in_wait, auto_now, adv;
    logic [3:0] y;
    if (!rst_n) begin
      m_since = 0; m_auto_run = 0; m_diff_run = 0;
      m_vec = 2'd0; m_err = 2'd0; m_led = 4'd0; m_rv = 1'b0; m_mis = 1'b0;
      m_deb = 1'b0; m_step = 1'b0; m_btn_hist = 2'd0; m_sw_hist = 2'd0;
      m_valid = 1'b1;
    end else begin
      in_check = (m_since == SETTLE);
      in_wait  = (m_since > SETTLE);
      auto_now = m_sw_hist[1];
      adv      = in_wait && (m_step || (auto_now && m_auto_run == DWELL - 1));
      m_rv     = in_check;
      if (in_check) begin
        y     = board_y(m_vec, fault_en);
        m_led = y;
        if (y != gates_resp(m_vec) && !m_mis) begin
          m_mis = 1'b1;
          m_err = m_vec;
        end
      end
      m_auto_run = (in_wait && auto_now && !adv) ? m_auto_run + 1 : 0;
      if (adv) begin
        m_vec   = m_vec + 2'd1;
        m_since = 0;
      end else if (m_since <= SETTLE) begin
        m_since++;
      end
      m_step = 1'b0;
      if (m_btn_hist[1] != m_deb) begin
        m_diff_run++;
        if (m_diff_run == DEB + 1) begin
          m_deb      = m_btn_hist[1];
          m_diff_run = 0;
          m_step     = m_deb;
        end
      end else begin
        m_diff_run = 0;
      end
      m_btn_hist = {m_btn_hist[0], btn_step};
      m_sw_hist  = {m_sw_hist[0], sw_auto};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cyc_vec", int'(vec), int'(m_vec));
      checkOutput("cyc_a_out", int'(a_out), int'(m_vec[1]));
      checkOutput("cyc_b_out", int'(b_out), int'(m_vec[0]));
      checkOutput("cyc_led", int'(led), int'(m_led));
      checkOutput("cyc_result_valid", int'(result_valid), int'(m_rv));
      checkOutput("cyc_mismatch", int'(mismatch), int'(m_mis));
      checkOutput("cyc_err_vec", int'(err_vec), int'(m_err));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0] auto_led  [5] = '{4'h8, 4'hE, 4'hE, 4'h7, 4'h8};
  logic [3:0] fault_led [4] = '{4'hE, 4'hA, 4'h7, 4'h8};

  initial begin
    int at, prev, rel, found;
    rst_n    = 1'b0;
    fault_en = 1'b0;
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("reset_vec", int'(vec), 0);
    checkOutput("reset_led", int'(led), 0);
    checkOutput("reset_valid", int'(result_valid), 0);
    checkOutput("reset_mismatch", int'(mismatch), 0);
    checkOutput("reset_err_vec", int'(err_vec), 0);

    $display("[TB] auto sequence");
    rst_n = 1'b1;
    rel   = cyc;
    prev  = rel;
    for (int i = 0; i < 5; i++) begin
      waitValid(30, at);
      checkOutput("auto_led", int'(led), int'(auto_led[i]));
      checkOutput("auto_period", at - prev, (i == 0) ? SETTLE + 1 : SETTLE + 1 + DWELL);
      prev = at;
    end
    checkOutput("auto_mismatch", int'(mismatch), 0);

    $display("[TB] step mode");
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("step_idle_vec", int'(vec), 0);
    for (int p = 1; p <= 3; p++) begin
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("step_vec", int'(vec), p);
    end
    applyStimulus(1'b0, 1'b0, 50);
    checkOutput("step_no_press_vec", int'(vec), 3);

    $display("[TB] bounce rejection");
    for (int i = 0; i < 10; i++) applyStimulus(i % 2 == 0, 1'b0, 2);
    checkOutput("bounce_no_step", int'(vec), 3);
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("bounce_before_step", int'(vec), 3);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("bounce_step_wrap", int'(vec), 0);
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("bounce_single_step", int'(vec), 0);
    applyStimulus(1'b0, 1'b0, 10);

    $display("[TB] fault injection");
    fault_en = 1'b1;
    sw_auto  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitValid(30, at);
      checkOutput("fault_led", int'(led), int'(fault_led[i]));
      checkOutput("fault_mismatch", int'(mismatch), (i >= 1) ? 1 : 0);
      checkOutput("fault_err_vec", int'(err_vec), (i >= 1) ? 2 : 0);
    end
    fault_en = 1'b0;

    $display("[TB] mid-operation reset");
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      if (vec == 2'd3) found = 1;
    end
    checkOutput("reset_reach_vec3", found, 1);
    checkOutput("sticky_before_reset", int'(mismatch), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_vec", int'(vec), 0);
    checkOutput("midreset_led", int'(led), 0);
    checkOutput("midreset_valid", int'(result_valid), 0);
    checkOutput("midreset_mismatch", int'(mismatch), 0);
    checkOutput("midreset_err_vec", int'(err_vec), 0);
    applyStimulus(1'b0, 1'b1, 2);
    rst_n = 1'b1;
    rel   = cyc;

    $display("[TB] mode switch");
    waitValid(10, at);
    checkOutput("mode_first_check", at - rel, SETTLE + 1);
    checkOutput("mode_first_led", int'(led), 8);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("mode_step_hold", int'(vec), 0);
    applyStimulus(1'b0, 1'b1, 9);
    checkOutput("mode_resume_early", int'(vec), 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("mode_resume_advance", int'(vec), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
